// File: rtl/conv_window_ctrl_if.sv
// Handshake bundle between the 5x5 window controller, the pixel source and the
// convolution consumer.
interface conv_window_ctrl_if #(
  parameter int CW = 5
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          buf_en;
  logic          win_valid;
  logic          win_ready;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy;
  logic          frame_done;

  modport master (
    input  start, in_valid, win_ready,
    output in_ready, buf_en, win_valid, win_row, win_col, busy, frame_done
  );

  modport slave (
    output start, in_valid, win_ready,
    input  in_ready, buf_en, win_valid, win_row, win_col, busy, frame_done
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Raster-scan controller for a 5x5 sliding-window buffer: counts accepted pixels,
// presents each complete window's top-left coordinate, and signals end of frame.
module conv_window_ctrl #(
  parameter int SIZE = 32,
  parameter int CW   = $clog2(SIZE)
) (
  input logic               clk,
  input logic               rst,
  conv_window_ctrl_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] SPAN = CW'(4);

  logic [1:0]    state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          win_valid_q;
  logic [CW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;
  logic          frame_done_q;
  logic          accept;
  logic          consume;

  // A pending window blocks new pixels unless it is being consumed this cycle.
  assign bus.in_ready = (state == RUN) && (!win_valid_q || bus.win_ready) && !rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign consume      = win_valid_q & bus.win_ready;

  assign bus.buf_en     = accept;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state == DRAIN) && consume;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (row == LAST && col == LAST) begin
              state <= DRAIN;
              row   <= '0;
              col   <= '0;
            end else if (col == LAST) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (consume) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Only pixels at row>=4 and col>=4 complete a window lying inside the frame.
      if (accept && row >= SPAN && col >= SPAN) begin
        win_valid_q <= 1'b1;
        win_row_q   <= row - SPAN;
        win_col_q   <= col - SPAN;
      end else if (consume) begin
        win_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl at SIZE=8: full frames, stalls, input gaps,
// mid-frame reset, ignored start and back-to-back frames.
module tb_conv_window_ctrl;

  localparam int SIZE = 8;
  localparam int CW   = 3;
  localparam int NWIN = (SIZE - 4) * (SIZE - 4);

  logic clk;
  logic rst;

  conv_window_ctrl_if #(.CW(CW)) bus ();

  conv_window_ctrl #(.SIZE(SIZE), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int failures  = 0;

  int          win_idx;
  int          accept_cnt;
  int          total_win;
  int          frames;
  bit          seen_win;
  bit          stall_prev;
  bit          prev_fd;
  logic [CW-1:0] prev_row;
  logic [CW-1:0] prev_col;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: windows must appear in raster order of (row, col) over a 4x4 grid.
  always @(negedge clk) begin
    if (rst) begin
      win_idx    = 0;
      accept_cnt = 0;
      seen_win   = 1'b0;
      stall_prev = 1'b0;
      prev_fd    = 1'b0;
    end else begin
      check_output("buf_en_is_accept", {31'd0, bus.buf_en}, {31'd0, bus.in_valid & bus.in_ready});
      if (stall_prev) begin
        check_output("stall_hold_valid", {31'd0, bus.win_valid}, 32'd1);
        check_output("stall_hold_row", {29'd0, bus.win_row}, {29'd0, prev_row});
        check_output("stall_hold_col", {29'd0, bus.win_col}, {29'd0, prev_col});
      end
      if (bus.win_valid && !bus.win_ready)
        check_output("stall_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      if (bus.win_valid && !seen_win) begin
        seen_win = 1'b1;
        check_output("first_win_latency", accept_cnt, 37);
        check_output("first_win_row", {29'd0, bus.win_row}, 32'd0);
        check_output("first_win_col", {29'd0, bus.win_col}, 32'd0);
      end
      if (bus.buf_en) accept_cnt++;
      if (bus.win_valid && bus.win_ready) begin
        check_output("win_row_order", {29'd0, bus.win_row}, win_idx / 4);
        check_output("win_col_order", {29'd0, bus.win_col}, win_idx % 4);
        win_idx++;
        total_win++;
      end
      if (bus.frame_done) begin
        check_output("frame_win_count", win_idx, NWIN);
        check_output("frame_accepts", accept_cnt, SIZE * SIZE);
        check_output("frame_done_single", {31'd0, prev_fd}, 32'd0);
        frames++;
        win_idx    = 0;
        accept_cnt = 0;
        seen_win   = 1'b0;
      end
      stall_prev = bus.win_valid & ~bus.win_ready;
      prev_row   = bus.win_row;
      prev_col   = bus.win_col;
      prev_fd    = bus.frame_done;
    end
  end

  task automatic do_reset();
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.win_ready = 1'b1;
    @(negedge clk);
    check_output("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_output("rst_buf_en", {31'd0, bus.buf_en}, 32'd0);
    check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rst_win_valid", {31'd0, bus.win_valid}, 32'd0);
    check_output("rst_win_row", {29'd0, bus.win_row}, 32'd0);
    check_output("rst_win_col", {29'd0, bus.win_col}, 32'd0);
    check_output("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check_output("rst_busy_held", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap_pct, input bit do_stall, input bit mid_start);
    int cyc;
    int stall_left;
    bit done;
    bit stalled;
    stall_left   = do_stall ? 5 : 0;
    done         = 1'b0;
    cyc          = 0;
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    bus.win_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!done && cyc < 2000) begin
      bus.in_valid  = ($urandom_range(0, 99) >= gap_pct);
      bus.win_ready = 1'b1;
      stalled       = 1'b0;
      if (stall_left > 0 && bus.win_valid && bus.win_row == 3'd1 && bus.win_col == 3'd2) begin
        bus.win_ready = 1'b0;
        bus.in_valid  = 1'b1;
        stall_left--;
        stalled = 1'b1;
      end
      bus.start = mid_start && cyc >= 10 && cyc < 13;
      @(negedge clk);
      if (stalled) begin
        check_output("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_output("stall_buf_en", {31'd0, bus.buf_en}, 32'd0);
      end
      if (bus.frame_done) begin
        done = 1'b1;
        check_output("busy_fall", {31'd0, bus.busy}, 32'd0);
      end
      cyc++;
      @(posedge clk); #1;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check_output("frame_timeout", {31'd0, done}, 32'd1);
    if (do_stall) check_output("stall_applied", stall_left, 0);
  endtask

  initial begin
    int f0;
    int w0;
    int n;
    int cyc;
    total_win     = 0;
    frames        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.win_ready = 1'b0;
    do_reset();

    f0 = frames; w0 = total_win;
    run_frame(0, 1'b0, 1'b0);
    check_output("full_frame_count", frames - f0, 1);
    check_output("full_frame_wins", total_win - w0, NWIN);

    f0 = frames; w0 = total_win;
    run_frame(0, 1'b1, 1'b0);
    check_output("stall_frame_wins", total_win - w0, NWIN);

    f0 = frames; w0 = total_win;
    run_frame(40, 1'b0, 1'b0);
    check_output("gap_frame_wins", total_win - w0, NWIN);

    f0 = frames; w0 = total_win;
    run_frame(0, 1'b0, 1'b1);
    check_output("midstart_frame_wins", total_win - w0, NWIN);
    check_output("midstart_frame_count", frames - f0, 1);

    // Abort a frame after pixel 30 and confirm a clean restart.
    f0 = frames; w0 = total_win;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.win_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 31 && cyc < 200) begin
      @(negedge clk);
      if (bus.buf_en) n++;
      cyc++;
      @(posedge clk); #1;
    end
    check_output("partial_accepts", n, 31);
    do_reset();
    check_output("abort_no_frame_done", frames - f0, 0);
    run_frame(0, 1'b0, 1'b0);
    check_output("after_abort_wins", total_win - w0, NWIN);

    f0 = frames; w0 = total_win;
    run_frame(0, 1'b0, 1'b0);
    run_frame(20, 1'b0, 1'b0);
    check_output("b2b_frames", frames - f0, 2);
    check_output("b2b_wins", total_win - w0, 2 * NWIN);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
